// File: rtl/bcd_to_binary_if.sv
// bcd_to_binary_if: start/BCD request and binary result bundle for bcd_to_binary
interface bcd_to_binary_if #(
    parameter int DECIMAL_DIGITS = 2,
    parameter int OUTPUT_WIDTH   = 7
);
    logic                          i_Start;
    logic [DECIMAL_DIGITS*4-1:0]   i_BCD;
    logic [OUTPUT_WIDTH-1:0]       o_Binary;
    logic                          o_DV;
    logic                          o_Busy;
    logic                          o_Invalid;
    logic                          o_Overflow;
    modport master (output i_Start, i_BCD, input o_Binary, o_DV, o_Busy, o_Invalid, o_Overflow);
    modport slave  (input i_Start, i_BCD, output o_Binary, o_DV, o_Busy, o_Invalid, o_Overflow);
endinterface

// File: rtl/bcd_to_binary.sv
// bcd_to_binary: iterative BCD-to-binary converter, one digit per clock, MS digit first
module bcd_to_binary #(
    parameter int DECIMAL_DIGITS = 2,
    parameter int OUTPUT_WIDTH   = 7
) (
    input  logic           i_Clock,
    input  logic           i_Reset_n,
    bcd_to_binary_if.slave bus
);
    localparam int BW = DECIMAL_DIGITS * 4;
    localparam int AW = OUTPUT_WIDTH + 4;
    localparam int CW = DECIMAL_DIGITS > 1 ? $clog2(DECIMAL_DIGITS) : 1;
    localparam logic [AW-1:0] MAX_EXT = {4'b0, {OUTPUT_WIDTH{1'b1}}};

    typedef enum logic {IDLE, CONVERT} state_t;

    state_t                  state_q, state_d;
    logic [BW-1:0]           shift_q, shift_d;
    logic [OUTPUT_WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    inv_q, inv_d;
    logic                    ovf_q, ovf_d;
    logic [OUTPUT_WIDTH-1:0] binary_q, binary_d;
    logic                    dv_q, dv_d;
    logic                    busy_q, busy_d;
    logic                    invalid_q, invalid_d;
    logic                    overflow_q, overflow_d;

    logic [3:0]              digit;
    logic [AW-1:0]           acc_sum;
    logic                    acc_ovf;
    logic [OUTPUT_WIDTH-1:0] acc_sat;
    logic                    inv_next;
    logic                    ovf_next;

    // acc is held clamped, so acc*10+15 always fits in AW bits and a
    // clamped acc keeps overflowing on every later digit
    assign digit    = shift_q[BW-1 -: 4];
    assign acc_sum  = ({4'b0, acc_q} << 3) + ({4'b0, acc_q} << 1) + AW'(digit);
    assign acc_ovf  = acc_sum > MAX_EXT;
    assign acc_sat  = acc_ovf ? MAX_EXT[OUTPUT_WIDTH-1:0] : acc_sum[OUTPUT_WIDTH-1:0];
    assign inv_next = inv_q | (digit > 4'd9);
    assign ovf_next = ovf_q | acc_ovf;

    assign bus.o_Binary   = binary_q;
    assign bus.o_DV       = dv_q;
    assign bus.o_Busy     = busy_q;
    assign bus.o_Invalid  = invalid_q;
    assign bus.o_Overflow = overflow_q;

    // Next-state: capture request in IDLE, fold in one digit per cycle in CONVERT
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        inv_d      = inv_q;
        ovf_d      = ovf_q;
        binary_d   = binary_q;
        dv_d       = 1'b0;
        busy_d     = busy_q;
        invalid_d  = invalid_q;
        overflow_d = overflow_q;
        if (state_q == IDLE) begin
            if (bus.i_Start) begin
                shift_d = bus.i_BCD;
                acc_d   = '0;
                cnt_d   = CW'(DECIMAL_DIGITS - 1);
                inv_d   = 1'b0;
                ovf_d   = 1'b0;
                busy_d  = 1'b1;
                state_d = CONVERT;
            end
        end else begin
            acc_d   = acc_sat;
            shift_d = shift_q << 4;
            inv_d   = inv_next;
            ovf_d   = ovf_next;
            cnt_d   = cnt_q - 1'b1;
            if (cnt_q == '0) begin
                binary_d   = acc_sat;
                invalid_d  = inv_next;
                overflow_d = ovf_next;
                dv_d       = 1'b1;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
        end
    end

    // State registers; reset aborts any conversion and zeroes all outputs
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            inv_q      <= 1'b0;
            ovf_q      <= 1'b0;
            binary_q   <= '0;
            dv_q       <= 1'b0;
            busy_q     <= 1'b0;
            invalid_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            inv_q      <= inv_d;
            ovf_q      <= ovf_d;
            binary_q   <= binary_d;
            dv_q       <= dv_d;
            busy_q     <= busy_d;
            invalid_q  <= invalid_d;
            overflow_q <= overflow_d;
        end
    end
endmodule

// File: tb/tb_bcd_to_binary.sv
// tb_bcd_to_binary: scoreboard bench for 2-digit and 3-digit converters
module tb_bcd_to_binary;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bcd_to_binary_if #(.DECIMAL_DIGITS(2), .OUTPUT_WIDTH(7)) a ();
    bcd_to_binary_if #(.DECIMAL_DIGITS(3), .OUTPUT_WIDTH(7)) b ();

    bcd_to_binary #(.DECIMAL_DIGITS(2), .OUTPUT_WIDTH(7)) dut_a (.i_Clock(clk), .i_Reset_n(rst_n), .bus(a));
    bcd_to_binary #(.DECIMAL_DIGITS(3), .OUTPUT_WIDTH(7)) dut_b (.i_Clock(clk), .i_Reset_n(rst_n), .bus(b));

    typedef struct packed {
        logic [6:0] bin;
        logic       inv;
        logic       ovf;
    } res_t;

    res_t qa[$];
    res_t qb[$];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic res_t model(input logic [11:0] bcd, input int nd);
        int acc = 0;
        res_t r = '0;
        for (int i = nd - 1; i >= 0; i--) begin
            logic [3:0] d;
            d = bcd[4*i +: 4];
            acc = acc * 10 + int'(d);
            if (d > 4'd9) r.inv = 1'b1;
            if (acc > 127) begin
                r.ovf = 1'b1;
                acc = 127;
            end
        end
        r.bin = 7'(acc);
        return r;
    endfunction

    task automatic go_a(input logic [7:0] v, input res_t e);
        @(negedge clk);
        a.i_BCD = v;
        a.i_Start = 1'b1;
        qa.push_back(e);
        @(posedge clk);
        #1 a.i_Start = 1'b0;
    endtask

    task automatic go_b(input logic [11:0] v, input res_t e);
        @(negedge clk);
        b.i_BCD = v;
        b.i_Start = 1'b1;
        qb.push_back(e);
        @(posedge clk);
        #1 b.i_Start = 1'b0;
    endtask

    task automatic wait_a(output res_t got, output int n, output int busy_n);
        n = 0;
        busy_n = 0;
        do begin
            @(negedge clk);
            n++;
            if (a.o_Busy) busy_n++;
        end while (!a.o_DV && n < 20);
        got = {a.o_Binary, a.o_Invalid, a.o_Overflow};
    endtask

    task automatic wait_b(output res_t got, output int n, output int busy_n);
        n = 0;
        busy_n = 0;
        do begin
            @(negedge clk);
            n++;
            if (b.o_Busy) busy_n++;
        end while (!b.o_DV && n < 20);
        got = {b.o_Binary, b.o_Invalid, b.o_Overflow};
    endtask

    task automatic test_reset;
        #1;
        n_cmp++;
        if ({a.o_Binary, a.o_DV, a.o_Busy, a.o_Invalid, a.o_Overflow} !== 11'h0) begin
            n_bad++;
            $display("FAIL reset_a_held got %h want 0", {a.o_Binary, a.o_DV, a.o_Busy, a.o_Invalid, a.o_Overflow});
        end
        n_cmp++;
        if ({b.o_Binary, b.o_DV, b.o_Busy, b.o_Invalid, b.o_Overflow} !== 11'h0) begin
            n_bad++;
            $display("FAIL reset_b_held got %h want 0", {b.o_Binary, b.o_DV, b.o_Busy, b.o_Invalid, b.o_Overflow});
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({a.o_Binary, a.o_DV, a.o_Busy, a.o_Invalid, a.o_Overflow} !== 11'h0) begin
            n_bad++;
            $display("FAIL reset_a_idle got %h want 0", {a.o_Binary, a.o_DV, a.o_Busy, a.o_Invalid, a.o_Overflow});
        end
    endtask

    task automatic test_basic;
        logic [7:0] vals [3] = '{8'h42, 8'h99, 8'h00};
        logic [6:0] want [3] = '{7'd42, 7'd99, 7'd0};
        res_t got, e;
        int n, bn;
        for (int i = 0; i < 3; i++) begin
            go_a(vals[i], {want[i], 1'b0, 1'b0});
            wait_a(got, n, bn);
            e = qa.size() > 0 ? qa.pop_front() : '1;
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL basic_result bcd=%h got %h want %h", vals[i], got, e);
            end
            n_cmp++;
            if (n !== 3) begin
                n_bad++;
                $display("FAIL basic_latency bcd=%h got %0d want 3", vals[i], n);
            end
            n_cmp++;
            if (bn !== 2) begin
                n_bad++;
                $display("FAIL basic_busy_cycles bcd=%h got %0d want 2", vals[i], bn);
            end
            @(negedge clk);
            n_cmp++;
            if (a.o_DV !== 1'b0 || {a.o_Binary, a.o_Invalid, a.o_Overflow} !== e) begin
                n_bad++;
                $display("FAIL basic_dv_hold got dv=%b res=%h want dv=0 res=%h", a.o_DV, {a.o_Binary, a.o_Invalid, a.o_Overflow}, e);
            end
        end
    endtask

    task automatic test_invalid;
        res_t got, e;
        int n, bn;
        go_a(8'h3A, {7'd40, 1'b1, 1'b0});
        wait_a(got, n, bn);
        e = qa.size() > 0 ? qa.pop_front() : '1;
        n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL invalid_3A got %h want %h", got, e);
        end
        go_a(8'h07, {7'd7, 1'b0, 1'b0});
        wait_a(got, n, bn);
        e = qa.size() > 0 ? qa.pop_front() : '1;
        n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL invalid_clears got %h want %h", got, e);
        end
    endtask

    task automatic test_overflow;
        logic [11:0] vals [5] = '{12'h128, 12'h127, 12'h999, 12'h0A0, 12'h000};
        res_t want [5] = '{{7'd127, 1'b0, 1'b1}, {7'd127, 1'b0, 1'b0}, {7'd127, 1'b0, 1'b1},
                           {7'd100, 1'b1, 1'b0}, {7'd0, 1'b0, 1'b0}};
        res_t got, e;
        int n, bn;
        for (int i = 0; i < 5; i++) begin
            go_b(vals[i], want[i]);
            wait_b(got, n, bn);
            e = qb.size() > 0 ? qb.pop_front() : '1;
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL overflow_result bcd=%h got %h want %h", vals[i], got, e);
            end
            n_cmp++;
            if (n !== 4 || bn !== 3) begin
                n_bad++;
                $display("FAIL overflow_timing bcd=%h got lat=%0d busy=%0d want lat=4 busy=3", vals[i], n, bn);
            end
        end
    endtask

    task automatic test_ignore_busy;
        res_t got, e;
        int dv_n = 0;
        @(negedge clk);
        a.i_BCD = 8'h42;
        a.i_Start = 1'b1;
        qa.push_back({7'd42, 1'b0, 1'b0});
        @(negedge clk);
        a.i_BCD = 8'h77;
        @(negedge clk);
        a.i_Start = 1'b0;
        @(negedge clk);
        got = {a.o_Binary, a.o_Invalid, a.o_Overflow};
        e = qa.size() > 0 ? qa.pop_front() : '1;
        n_cmp++;
        if (a.o_DV !== 1'b1 || got !== e) begin
            n_bad++;
            $display("FAIL ignore_busy_result got dv=%b res=%h want dv=1 res=%h", a.o_DV, got, e);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (a.o_DV) dv_n++;
        end
        n_cmp++;
        if (dv_n !== 0) begin
            n_bad++;
            $display("FAIL ignore_busy_extra_dv got %0d want 0", dv_n);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] vals [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
        logic [6:0] want [4] = '{7'd12, 7'd34, 7'd56, 7'd78};
        res_t got, e;
        int n, bn;
        @(negedge clk);
        a.i_BCD = vals[0];
        a.i_Start = 1'b1;
        qa.push_back({want[0], 1'b0, 1'b0});
        for (int k = 0; k < 4; k++) begin
            wait_a(got, n, bn);
            e = qa.size() > 0 ? qa.pop_front() : '1;
            n_cmp++;
            if (n !== 3) begin
                n_bad++;
                $display("FAIL b2b_spacing k=%0d got %0d want 3", k, n);
            end
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL b2b_result k=%0d got %h want %h", k, got, e);
            end
            if (k < 3) begin
                a.i_BCD = vals[k+1];
                qa.push_back({want[k+1], 1'b0, 1'b0});
            end else begin
                a.i_Start = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid;
        res_t got, e;
        int n, bn;
        int dv_n = 0;
        @(negedge clk);
        a.i_BCD = 8'h88;
        a.i_Start = 1'b1;
        @(posedge clk);
        #1 a.i_Start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({a.o_Binary, a.o_DV, a.o_Busy, a.o_Invalid, a.o_Overflow} !== 11'h0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs got %h want 0", {a.o_Binary, a.o_DV, a.o_Busy, a.o_Invalid, a.o_Overflow});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (a.o_DV || a.o_Busy) dv_n++;
        end
        n_cmp++;
        if (dv_n !== 0) begin
            n_bad++;
            $display("FAIL reset_mid_aborted got %0d dv/busy cycles want 0", dv_n);
        end
        go_a(8'h57, {7'd57, 1'b0, 1'b0});
        wait_a(got, n, bn);
        e = qa.size() > 0 ? qa.pop_front() : '1;
        n_cmp++;
        if (got !== e || n !== 3) begin
            n_bad++;
            $display("FAIL reset_mid_fresh got %h lat=%0d want %h lat=3", got, n, e);
        end
    endtask

    task automatic test_random;
        res_t got, e;
        int n, bn;
        logic [7:0] v;
        for (int i = 0; i < 16; i++) begin
            v = 8'($urandom_range(0, 255));
            go_a(v, model({4'h0, v}, 2));
            wait_a(got, n, bn);
            e = qa.size() > 0 ? qa.pop_front() : '1;
            n_cmp++;
            if (got !== e || n !== 3) begin
                n_bad++;
                $display("FAIL random bcd=%h got %h lat=%0d want %h lat=3", v, got, n, e);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a.i_Start = 1'b0;
        a.i_BCD = '0;
        b.i_Start = 1'b0;
        b.i_BCD = '0;
        repeat (2) @(negedge clk);
        test_reset;
        test_basic;
        test_invalid;
        test_overflow;
        test_ignore_busy;
        test_back_to_back;
        test_reset_mid;
        test_random;
        n_cmp++;
        if (qa.size() + qb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain got %0d left want 0", qa.size() + qb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
